// File: rtl/slink_tx_os_gen_pkg.sv
// -----------------------------------------------------------------------------
// slink_tx_os_gen_pkg
// Shared constants and types for the S-Link transmit ordered-set generator.
//   - Ordered-set symbol bytes (COM, TS1/TS2 fill, SDS header/fill)
//   - os_sel encodings
//   - Generator state encoding (also driven out on gen_state)
//   - Helpers: last beat index per lane width, os_sel -> state mapping
// -----------------------------------------------------------------------------
package slink_tx_os_gen_pkg;

  // Ordered-set symbol bytes
  localparam logic [7:0] TSX_BYTE0 = 8'hBC;  // COM, first byte of TS1/TS2
  localparam logic [7:0] TS1_BYTEX = 8'h4A;  // TS1 bytes 1..15
  localparam logic [7:0] TS2_BYTEX = 8'h45;  // TS2 bytes 1..15
  localparam logic [7:0] SDS_BYTE0 = 8'hE1;  // SDS first byte
  localparam logic [7:0] SDS_BYTEX = 8'h55;  // SDS bytes 1..15

  // os_sel encodings
  localparam logic [1:0] OS_SEL_DATA = 2'd0;
  localparam logic [1:0] OS_SEL_TS1  = 2'd1;
  localparam logic [1:0] OS_SEL_TS2  = 2'd2;
  localparam logic [1:0] OS_SEL_SDS  = 2'd3;

  localparam int          OS_BYTES = 16;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    GEN_IDLE = 3'd0,
    GEN_TS1  = 3'd1,
    GEN_TS2  = 3'd2,
    GEN_SDS  = 3'd3,
    GEN_DATA = 3'd4
  } gen_state_e;

  // Index of the final beat of a 16-byte set for a given lane width.
  function automatic logic [3:0] last_beat(input int data_width);
    return 4'(OS_BYTES / (data_width / 8) - 1);
  endfunction

  // Ordered-set state requested by os_sel. DATA maps to SDS because data
  // may only follow a completed SDS set.
  function automatic gen_state_e sel_to_state(input logic [1:0] sel);
    case (sel)
      OS_SEL_TS1: return GEN_TS1;
      OS_SEL_TS2: return GEN_TS2;
      OS_SEL_SDS: return GEN_SDS;
      default:    return GEN_SDS;
    endcase
  endfunction

endpackage

// File: rtl/slink_tx_os_beat.sv
// -----------------------------------------------------------------------------
// slink_tx_os_beat
// Produces one lane-beat of the current ordered set. Byte n of the set sits
// at beat n/BPB, byte lane n%BPB (lowest-numbered byte in the LSBs).
// Parameters:
//   DATA_WIDTH  bits per lane beat (8, 16 or 32)
// Ports:
//   set_type_i  current generator state (TS1/TS2/SDS produce a pattern,
//               anything else produces zero)
//   beat_idx_i  beat index within the set
//   beat_o      lane beat
// -----------------------------------------------------------------------------
module slink_tx_os_beat
  import slink_tx_os_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  gen_state_e            set_type_i,
  input  logic [3:0]            beat_idx_i,
  output logic [DATA_WIDTH-1:0] beat_o
);

  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;

  logic [7:0] head_byte;
  logic [7:0] fill_byte;

  always_comb begin
    head_byte = '0;
    fill_byte = '0;
    case (set_type_i)
      GEN_TS1: begin
        head_byte = TSX_BYTE0;
        fill_byte = TS1_BYTEX;
      end
      GEN_TS2: begin
        head_byte = TSX_BYTE0;
        fill_byte = TS2_BYTEX;
      end
      GEN_SDS: begin
        head_byte = SDS_BYTE0;
        fill_byte = SDS_BYTEX;
      end
      default: ;
    endcase
  end

  // Only byte 0 of the set differs from the fill byte, and it only appears
  // in byte lane 0 of beat 0.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_BEAT; gi++) begin : g_byte
      if (gi == 0) begin : g_head
        assign beat_o[7:0] = (beat_idx_i == 4'd0) ? head_byte : fill_byte;
      end else begin : g_fill
        assign beat_o[gi*8 +: 8] = fill_byte;
      end
    end
  endgenerate

endmodule

// File: rtl/slink_tx_os_gen.sv
// -----------------------------------------------------------------------------
// slink_tx_os_gen
// S-Link transmit ordered-set generator. Emits TS1/TS2/SDS ordered sets
// (16 bytes each) on all active lanes, then passes link data through once an
// SDS set has been sent and os_sel selects DATA.
// Parameters:
//   DATA_WIDTH   bits per lane per beat (8, 16, 32)
//   NUM_LANES    physical lanes
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   enable             generator on; 0 returns to IDLE on the next edge
//   active_lanes       lanes 0..(1<<active_lanes)-1 are active
//   os_sel             0=DATA 1=TS1 2=TS2 3=SDS, sampled at set boundaries
//   tx_data_in/valid   link data in; tx_data_ready accepts it in DATA
//   tx_data_out        registered lane data
//   tx_data_valid_out  registered per-lane valid
//   os_boundary        combinational, high on the last beat of a set
//   gen_state          current state (IDLE=0 TS1=1 TS2=2 SDS=3 DATA=4)
// Build option:
//   SLINK_TX_OS_COUNT_EN adds ts1_sent_cnt / ts2_sent_cnt (saturating
//   counts of completed sets, cleared by reset or enable=0).
// -----------------------------------------------------------------------------
module slink_tx_os_gen
  import slink_tx_os_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [2:0]                      active_lanes,
  input  logic [1:0]                      os_sel,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] tx_data_in,
  input  logic                            tx_data_valid,
  output logic                            tx_data_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] tx_data_out,
  output logic [NUM_LANES-1:0]            tx_data_valid_out,
  output logic                            os_boundary,
  output logic [2:0]                      gen_state
`ifdef SLINK_TX_OS_COUNT_EN
  ,
  output logic [15:0]                     ts1_sent_cnt,
  output logic [15:0]                     ts2_sent_cnt
`endif
);

  localparam logic [3:0] LAST_BEAT = last_beat(DATA_WIDTH);
  localparam int         LW        = NUM_LANES * DATA_WIDTH;

  gen_state_e            state_q, state_d;
  logic [3:0]            beat_q, beat_d;
  logic                  in_os_set;
  logic                  last_beat_hit;
  logic                  data_accept;
  logic [DATA_WIDTH-1:0] os_beat;
  logic [NUM_LANES-1:0]  lane_active;
  logic [LW-1:0]         data_out_d, data_out_q;
  logic [NUM_LANES-1:0]  valid_out_d, valid_out_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= GEN_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic. os_sel only matters in IDLE, at a set boundary, or in
  // DATA; mid-set changes are ignored.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (!enable) begin
      state_d = GEN_IDLE;
      beat_d  = '0;
    end else begin
      case (state_q)
        GEN_IDLE: begin
          state_d = sel_to_state(os_sel);
          beat_d  = '0;
        end
        GEN_TS1, GEN_TS2, GEN_SDS: begin
          if (last_beat_hit) begin
            beat_d = '0;
            if (os_sel == OS_SEL_DATA) begin
              // Data may only follow a completed SDS set.
              state_d = (state_q == GEN_SDS) ? GEN_DATA : GEN_SDS;
            end else begin
              state_d = sel_to_state(os_sel);
            end
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
        GEN_DATA: begin
          if (os_sel != OS_SEL_DATA) begin
            state_d = sel_to_state(os_sel);
            beat_d  = '0;
          end
        end
        default: begin
          state_d = GEN_IDLE;
          beat_d  = '0;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    in_os_set     = (state_q == GEN_TS1) || (state_q == GEN_TS2) ||
                    (state_q == GEN_SDS);
    last_beat_hit = in_os_set && (beat_q == LAST_BEAT);
    tx_data_ready = (state_q == GEN_DATA) && (os_sel == OS_SEL_DATA);
    data_accept   = tx_data_ready && tx_data_valid;
  end

  assign os_boundary = last_beat_hit;
  assign gen_state   = state_q;

  // One pattern generator shared by every lane.
  slink_tx_os_beat #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_beat (
    .set_type_i (state_q),
    .beat_idx_i (beat_q),
    .beat_o     (os_beat)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_active[gi] = (32'(gi) < (32'd1 << active_lanes));
      assign data_out_d[gi*DATA_WIDTH +: DATA_WIDTH] =
          !lane_active[gi] ? '0 :
          in_os_set        ? os_beat :
          data_accept      ? tx_data_in[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      assign valid_out_d[gi] = lane_active[gi] && (in_os_set || data_accept);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q  <= '0;
      valid_out_q <= '0;
    end else begin
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign tx_data_out       = data_out_q;
  assign tx_data_valid_out = valid_out_q;

`ifdef SLINK_TX_OS_COUNT_EN
  logic [15:0] ts1_cnt_q, ts1_cnt_d;
  logic [15:0] ts2_cnt_q, ts2_cnt_d;

  // A set counts as sent on the edge that leaves its final beat.
  always_comb begin
    ts1_cnt_d = ts1_cnt_q;
    ts2_cnt_d = ts2_cnt_q;
    if (!enable) begin
      ts1_cnt_d = '0;
      ts2_cnt_d = '0;
    end else if (last_beat_hit) begin
      if ((state_q == GEN_TS1) && (ts1_cnt_q != CNT_MAX)) ts1_cnt_d = ts1_cnt_q + 16'd1;
      if ((state_q == GEN_TS2) && (ts2_cnt_q != CNT_MAX)) ts2_cnt_d = ts2_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts1_cnt_q <= '0;
      ts2_cnt_q <= '0;
    end else begin
      ts1_cnt_q <= ts1_cnt_d;
      ts2_cnt_q <= ts2_cnt_d;
    end
  end

  assign ts1_sent_cnt = ts1_cnt_q;
  assign ts2_sent_cnt = ts2_cnt_q;
`endif

endmodule

// File: tb/tb_slink_tx_os_gen.sv
`timescale 1ns/1ps
module tb_slink_tx_os_gen;

  localparam logic [7:0] B_COM  = 8'hBC;
  localparam logic [7:0] B_TS1  = 8'h4A;
  localparam logic [7:0] B_TS2  = 8'h45;
  localparam logic [7:0] B_SDS0 = 8'hE1;
  localparam logic [7:0] B_SDSX = 8'h55;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         en;
  logic [2:0]   al;
  logic [1:0]   sel;
  logic         vin;
  logic [127:0] tin;

  logic         rdy8, bnd8;
  logic [31:0]  dout8;
  logic [3:0]   vout8;
  logic [2:0]   gs8;
  logic         rdy32, bnd32;
  logic [127:0] dout32;
  logic [3:0]   vout32;
  logic [2:0]   gs32;
`ifdef SLINK_TX_OS_COUNT_EN
  logic [15:0]  c1_8, c2_8, c1_32, c2_32;
`endif

  slink_tx_os_gen #(.DATA_WIDTH(8), .NUM_LANES(4)) u_dut8 (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (en),
    .active_lanes      (al),
    .os_sel            (sel),
    .tx_data_in        (tin[31:0]),
    .tx_data_valid     (vin),
    .tx_data_ready     (rdy8),
    .tx_data_out       (dout8),
    .tx_data_valid_out (vout8),
    .os_boundary       (bnd8),
    .gen_state         (gs8)
`ifdef SLINK_TX_OS_COUNT_EN
    ,
    .ts1_sent_cnt      (c1_8),
    .ts2_sent_cnt      (c2_8)
`endif
  );

  slink_tx_os_gen #(.DATA_WIDTH(32), .NUM_LANES(4)) u_dut32 (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (en),
    .active_lanes      (al),
    .os_sel            (sel),
    .tx_data_in        (tin),
    .tx_data_valid     (vin),
    .tx_data_ready     (rdy32),
    .tx_data_out       (dout32),
    .tx_data_valid_out (vout32),
    .os_boundary       (bnd32),
    .gen_state         (gs32)
`ifdef SLINK_TX_OS_COUNT_EN
    ,
    .ts1_sent_cnt      (c1_32),
    .ts2_sent_cnt      (c2_32)
`endif
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each instance walks a 16-byte ordered set by byte offset.
  // Index 0 = 8-bit lanes (1 byte/beat), index 1 = 32-bit lanes (4 bytes/beat).
  // m_st uses the published gen_state numbering.
  // ---------------------------------------------------------------------------
  int           m_st  [2];
  int           m_pos [2];
  logic [127:0] m_dat [2];
  logic [3:0]   m_vld [2];

  function automatic logic [7:0] set_byte(input int st, input int idx);
    if (idx == 0) return (st == 3) ? B_SDS0 : B_COM;
    case (st)
      1:       return B_TS1;
      2:       return B_TS2;
      default: return B_SDSX;
    endcase
  endfunction

  function automatic int bpb_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int lanes_on(input logic [2:0] a);
    return (a >= 3'd2) ? 4 : (1 << a);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int           bpb;
    int           nl;
    logic [127:0] nd;
    logic [3:0]   nv;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] = 0; m_pos[i] = 0; m_dat[i] = '0; m_vld[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bpb = bpb_of(i);
        nl  = lanes_on(al);
        nd  = '0;
        nv  = '0;
        if (m_st[i] >= 1 && m_st[i] <= 3) begin
          for (int l = 0; l < nl; l++) begin
            nv[l] = 1'b1;
            for (int b = 0; b < bpb; b++) nd[(l*bpb+b)*8 +: 8] = set_byte(m_st[i], m_pos[i] + b);
          end
        end else if (m_st[i] == 4 && sel == 2'd0 && vin) begin
          for (int l = 0; l < nl; l++) begin
            nv[l] = 1'b1;
            for (int b = 0; b < bpb; b++) nd[(l*bpb+b)*8 +: 8] = tin[(l*bpb+b)*8 +: 8];
          end
        end
        m_dat[i] = nd;
        m_vld[i] = nv;
        if (!en) begin
          m_st[i] = 0; m_pos[i] = 0;
        end else if (m_st[i] == 0) begin
          m_st[i] = (sel == 2'd0) ? 3 : int'(sel); m_pos[i] = 0;
        end else if (m_st[i] == 4) begin
          if (sel != 2'd0) begin m_st[i] = int'(sel); m_pos[i] = 0; end
        end else if (m_pos[i] + bpb >= 16) begin
          m_st[i]  = (sel != 2'd0) ? int'(sel) : ((m_st[i] == 3) ? 4 : 3);
          m_pos[i] = 0;
        end else begin
          m_pos[i] = m_pos[i] + bpb;
        end
      end
    end
  end

  task automatic check_model();
    logic eb0, eb1;
    eb0 = (m_st[0] >= 1 && m_st[0] <= 3) && (m_pos[0] + 1 == 16);
    eb1 = (m_st[1] >= 1 && m_st[1] <= 3) && (m_pos[1] + 4 == 16);
    chk("m_state8",  128'(gs8),    128'(m_st[0]));
    chk("m_bnd8",    128'(bnd8),   128'(eb0));
    chk("m_rdy8",    128'(rdy8),   128'(m_st[0] == 4 && sel == 2'd0));
    chk("m_data8",   128'(dout8),  m_dat[0]);
    chk("m_valid8",  128'(vout8),  128'(m_vld[0]));
    chk("m_state32", 128'(gs32),   128'(m_st[1]));
    chk("m_bnd32",   128'(bnd32),  128'(eb1));
    chk("m_rdy32",   128'(rdy32),  128'(m_st[1] == 4 && sel == 2'd0));
    chk("m_data32",  dout32,       m_dat[1]);
    chk("m_valid32", 128'(vout32), 128'(m_vld[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; en = 1'b0; sel = 2'd1; al = 3'd2; vin = 1'b0; tin = '0;
    #1;
    chk("rst_state8", 128'(gs8),   128'(0));
    chk("rst_data8",  128'(dout8), 128'(0));
    chk("rst_vld8",   128'(vout8), 128'(0));
    chk("rst_rdy8",   128'(rdy8),  128'(0));
    chk("rst_bnd8",   128'(bnd8),  128'(0));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    string      name;
    bit         en;
    bit [2:0]   al;
    bit [1:0]   sel;
    int         cyc;
    bit [2:0]   e_st;
    bit         e_bnd;
    bit         e_rdy;
    bit [7:0]   e_b0;
    bit [3:0]   e_vld;
  } vec_t;

  function automatic vec_t mk(input string n, input bit e, input bit [2:0] a, input bit [1:0] s,
                              input int c, input bit [2:0] st, input bit bd, input bit rd,
                              input bit [7:0] b0, input bit [3:0] v);
    vec_t r;
    r.name = n; r.en = e; r.al = a; r.sel = s; r.cyc = c;
    r.e_st = st; r.e_bnd = bd; r.e_rdy = rd; r.e_b0 = b0; r.e_vld = v;
    return r;
  endfunction

  vec_t vt[$];

  initial begin
    // Sequence from reset on the 8-bit instance; expected values by hand.
    vt.push_back(mk("reset_idle",  0, 2, 1,  1, 0, 0, 0, 8'h00,  4'h0));
    vt.push_back(mk("ts1_enter",   1, 2, 1,  1, 1, 0, 0, 8'h00,  4'h0));
    vt.push_back(mk("ts1_beat0",   1, 2, 1,  1, 1, 0, 0, B_COM,  4'hF));
    vt.push_back(mk("ts1_beat15",  1, 2, 1, 14, 1, 1, 0, B_TS1,  4'hF));
    vt.push_back(mk("to_ts2",      1, 2, 2,  1, 2, 0, 0, B_TS1,  4'hF));
    vt.push_back(mk("ts2_beat0",   1, 2, 0,  1, 2, 0, 0, B_COM,  4'hF));
    vt.push_back(mk("ts2_last",    1, 2, 0, 14, 2, 1, 0, B_TS2,  4'hF));
    vt.push_back(mk("sds_insert",  1, 2, 0,  1, 3, 0, 0, B_TS2,  4'hF));
    vt.push_back(mk("sds_beat0",   1, 2, 0,  1, 3, 0, 0, B_SDS0, 4'hF));
    vt.push_back(mk("sds_last",    1, 2, 0, 14, 3, 1, 0, B_SDSX, 4'hF));
    vt.push_back(mk("data_enter",  1, 2, 0,  1, 4, 0, 1, B_SDSX, 4'hF));
    vt.push_back(mk("data_novld",  1, 2, 0,  1, 4, 0, 1, 8'h00,  4'h0));
    vt.push_back(mk("disable",     0, 2, 0,  1, 0, 0, 0, 8'h00,  4'h0));
    vt.push_back(mk("one_lane",    1, 0, 1,  2, 1, 0, 0, B_COM,  4'h1));

    do_reset();
    foreach (vt[k]) begin
      en = vt[k].en; al = vt[k].al; sel = vt[k].sel;
      repeat (vt[k].cyc) tick();
      chk({vt[k].name, "_state"}, 128'(gs8),        128'(vt[k].e_st));
      chk({vt[k].name, "_bnd"},   128'(bnd8),       128'(vt[k].e_bnd));
      chk({vt[k].name, "_rdy"},   128'(rdy8),       128'(vt[k].e_rdy));
      chk({vt[k].name, "_byte0"}, 128'(dout8[7:0]), 128'(vt[k].e_b0));
      chk({vt[k].name, "_valid"}, 128'(vout8),      128'(vt[k].e_vld));
      $display("vec %0d %s: gen_state=%0d lane0=%02h valid=%b", k, vt[k].name, gs8, dout8[7:0], vout8);
    end

    // 32-bit lanes: TS2 sets of 4 beats, one SDS set, then data.
    do_reset();
    en = 1'b1; sel = 2'd2; al = 3'd2;
    tick(); chk("w32_ts2_state", 128'(gs32), 128'(2));
    tick(); chk("w32_ts2_beat0", 128'(dout32[31:0]), 128'(32'h454545BC));
    sel = 2'd0;
    tick(); tick(); chk("w32_ts2_bnd", 128'(bnd32), 128'(1));
    tick(); chk("w32_sds_state", 128'(gs32), 128'(3));
    tick(); chk("w32_sds_beat0", 128'(dout32[31:0]), 128'(32'h555555E1));
    tick(); tick(); tick();
    chk("w32_data_state", 128'(gs32), 128'(4));
    chk("w32_data_ready", 128'(rdy32), 128'(1));
    vin = 1'b1; tin = {$urandom, $urandom, $urandom, $urandom};
    tick();
    chk("w32_data_out", dout32, tin);
    chk("w32_data_vld", 128'(vout32), 128'(4'hF));
    $display("seq w32: TS2 -> SDS -> DATA done");

    // os_sel change at beat 5 of a TS1 set is ignored until the boundary.
    do_reset();
    en = 1'b1; sel = 2'd1;
    repeat (6) tick();
    sel = 2'd2;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("midset_state", 128'(gs8), 128'(1));
      if (k == 10) chk("midset_bnd", 128'(bnd8), 128'(1));
    end
    tick(); chk("midset_new_state", 128'(gs8), 128'(2));
    $display("seq midset: TS1 completed before TS2");

    // enable dropped at SDS beat 3, then restored.
    do_reset();
    en = 1'b1; sel = 2'd3;
    repeat (4) tick();
    en = 1'b0;
    tick(); chk("dis_state", 128'(gs8), 128'(0));
    chk("dis_last_beat", 128'(dout8[7:0]), 128'(B_SDSX));
    tick(); chk("dis_data_zero", 128'(dout8), 128'(0));
    chk("dis_vld_zero", 128'(vout8), 128'(0));
    en = 1'b1;
    tick(); chk("reen_state", 128'(gs8), 128'(3));
    tick(); chk("reen_beat0", 128'(dout8[7:0]), 128'(B_SDS0));
    chk("reen_vld", 128'(vout8), 128'(4'hF));
    $display("seq disable: SDS restarted at beat 0");

    // Reset asserted mid-set, then released.
    do_reset();
    en = 1'b1; sel = 2'd1;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_state", 128'(gs8), 128'(0));
    chk("midrst_data",  128'(dout8), 128'(0));
    chk("midrst_vld",   128'(vout8), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    tick(); chk("midrst_restart", 128'(gs8), 128'(1));
    chk("midrst_no_partial", 128'(vout8), 128'(0));
    tick(); chk("midrst_beat0", 128'(dout8[7:0]), 128'(B_COM));
    $display("seq midreset: restarted from IDLE");

    // Single active lane for 200 cycles of random activity.
    do_reset();
    al = 3'd0; en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      en  = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
      vin = 1'($urandom_range(0, 1));
      tin = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk("lane_off_data8",  128'(dout8[31:8]),    128'(0));
      chk("lane_off_vld8",   128'(vout8[3:1]),     128'(0));
      chk("lane_off_data32", 128'(dout32[127:32]), 128'(0));
      chk("lane_off_vld32",  128'(vout32[3:1]),    128'(0));
    end
    $display("seq lane_off: 200 cycles with one active lane");

    // Random traffic against the model.
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      en = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 15) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) al = 3'($urandom_range(0, 7));
      vin = 1'($urandom_range(0, 1));
      tin = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    $display("seq random: 2000 cycles");

`ifdef SLINK_TX_OS_COUNT_EN
    do_reset();
    chk("cnt_rst", 128'(c1_8), 128'(0));
    en = 1'b1; sel = 2'd1;
    repeat (81) tick();
    chk("ts1_cnt8",  128'(c1_8),  128'(5));
    chk("ts2_cnt8",  128'(c2_8),  128'(0));
    chk("ts1_cnt32", 128'(c1_32), 128'(20));
    en = 1'b0;
    tick(); chk("cnt_clear", 128'(c1_8), 128'(0));
    $display("seq counters: ts1=%0d after 5 sets", 5);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/slink_tx_os_gen.md
SLINK_TX_OS_GEN -- requirements
Module: slink_tx_os_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per lane per beat (8, 16 or 32).
REQ-002 SHALL have parameter NUM_LANES, default 4, meaning the number of physical lanes.
REQ-003 SHALL have ports: clk input 1, the single clock; reset_n input 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports: enable input 1 (generator on); active_lanes input 3 (lanes 0..(1<<active_lanes)-1 active); os_sel input 2 (0=DATA, 1=TS1, 2=TS2, 3=SDS).
REQ-005 SHALL have ports: tx_data_in input NUM_LANES*DATA_WIDTH (link data); tx_data_valid input 1; tx_data_ready output 1.
REQ-006 SHALL have ports: tx_data_out output NUM_LANES*DATA_WIDTH; tx_data_valid_out output NUM_LANES; os_boundary output 1 (last beat of an ordered set); gen_state output 3.

Function
REQ-007 SHALL implement states IDLE, TS1, TS2, SDS, DATA (gen_state 0..4).
REQ-008 SHALL form each ordered set from 16 bytes: byte0 = COM (TSX_BYTE0) with bytes 1-15 = TS1_BYTEX or TS2_BYTEX; SDS = SDS_BYTE0, then 15 x SDS_BYTEX.
- Lowest-numbered byte goes in the LSBs of each beat.
- Beats per set: 16 / 8 / 4 for DATA_WIDTH 8 / 16 / 32.
REQ-009 SHALL hold a 4-bit beat counter that resets to 0 on every state entry and wraps after the last beat of the set.
REQ-010 SHALL leave IDLE when enable=1 for the os_sel state; os_sel=DATA from IDLE selects SDS.
REQ-011 SHALL sample os_sel only on the last beat of an ordered set (os_boundary=1); mid-set changes of os_sel are ignored.
REQ-012 SHALL treat os_sel=DATA at a boundary as follows: go to DATA only if the set just completed was SDS, otherwise emit SDS first.
REQ-013 SHALL, in DATA, move on the next cycle to the os_sel state when os_sel!=DATA, starting that ordered set at beat 0.
REQ-014 SHALL drive tx_data_ready = (state==DATA) && (os_sel==DATA); the data handshake completes when valid and ready are both 1.
REQ-015 SHALL register all outputs with one cycle of latency from the state/beat or from the accepted data beat.
REQ-016 SHALL set tx_data_valid_out to 1 on active lanes for every ordered-set beat and for accepted data beats, and to 0 in DATA when tx_data_valid=0 (data zeroed).
REQ-017 SHALL drive zero data and valid=0 on inactive lanes at all times; all active lanes carry identical ordered-set beats in the same cycle.
REQ-018 SHALL, when enable=0, go to IDLE on the next edge from any state (even mid-set), with outputs 0 the cycle after.
REQ-019 SHALL raise os_boundary combinationally on the final beat of TS1/TS2/SDS, and hold it at 0 in IDLE and DATA.

Reset
REQ-020 SHALL, during reset_n=0: state IDLE, beat counter 0, tx_data_out 0, tx_data_valid_out 0, tx_data_ready 0, os_boundary 0, gen_state 0.
REQ-021 SHALL, after reset_n deasserts mid-operation, restart from IDLE with no partial ordered set emitted.

Configuration
REQ-022 SHALL, when macro SLINK_TX_OS_COUNT_EN is defined, add outputs ts1_sent_cnt and ts2_sent_cnt (16 bits each).
- Each counts completed sets of its type and saturates at 0xFFFF.
- Both clear on reset and on enable=0.
REQ-023 SHALL, without SLINK_TX_OS_COUNT_EN, have neither port nor counter logic.

Structure
REQ-024 SHALL take TSX_BYTE0, TS1_BYTEX, TS2_BYTEX, SDS_BYTE0, SDS_BYTEX and the os_sel encodings from the shared slink include/package; no local literals.
REQ-025 SHALL place beat-pattern generation in sub-module slink_tx_os_beat (inputs set type, beat index, DATA_WIDTH; output one lane beat), instanced once and fanned out to lanes.

Verification
REQ-026 SHALL cover: DATA_WIDTH=8, active_lanes=2, os_sel=TS1, enable=1 -> 16-beat sets on lanes 0-3 (beat0 TSX_BYTE0, then TS1_BYTEX), os_boundary on beat 15.
REQ-027 SHALL cover: DATA_WIDTH=32, os_sel TS2 then DATA -> TS2 sets of 4 beats, then one SDS set (first beat {3x SDS_BYTEX, SDS_BYTE0}), then DATA with tx_data_ready=1.
REQ-028 SHALL cover: active_lanes=0, NUM_LANES=4 -> lanes 1-3 output 0 with valid 0 for 200 cycles.
REQ-029 SHALL cover: os_sel changed on beat 5 of a TS1 set -> set completes all 16 beats before the new state.
REQ-030 SHALL cover: enable dropped mid-SDS at beat 3, then re-asserted -> IDLE, outputs 0, new set starts at beat 0.
REQ-031 SHALL cover: SLINK_TX_OS_COUNT_EN with 5 TS1 sets -> ts1_sent_cnt=5, ts2_sent_cnt=0.
